// File: rtl/vector_const_bank.sv
// vector_const_bank
// Writable bank of DEPTH constant vectors, each LANES lanes of DATA_W bits.
// A vector is loaded one lane per beat into a staging register and committed
// to the array in a single edge, so readers never see a half-written vector.
// A clear sweep zeroes the array after reset and on software request.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   rd_en, rd_idx       read request; result appears one cycle later
//   rd_valid, rd_data   read response (lane k at bits [k*DATA_W +: DATA_W])
//   rd_err              pulses with rd_valid for an out-of-range index
//   ld_valid, ld_ready  load beat handshake
//   ld_idx, ld_data     target vector (first beat only) and lane data
//   ld_err              pulses after a commit to an out-of-range index
//   clr_req             request a full-bank clear (honoured in IDLE only)
//   busy                high while clearing or in the middle of a load
module vector_const_bank #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int DEPTH  = 2,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic                    rd_valid,
  output logic [LANES*DATA_W-1:0] rd_data,
  output logic                    rd_err,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [IDX_W-1:0]        ld_idx,
  input  logic [DATA_W-1:0]       ld_data,
  output logic                    ld_err,
  input  logic                    clr_req,
  output logic                    busy
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int VEC_W  = LANES * DATA_W;

  localparam logic [CNT_W-1:0]  LAST_ENTRY = CNT_W'(DEPTH - 1);
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    clr_cnt, clr_cnt_nx;
  logic [LANE_W-1:0]   lane_cnt, lane_cnt_nx;
  logic [IDX_W-1:0]    target;
  logic                accept;
  logic                commit;
  logic                clear_wr;
  logic [LANE_W-1:0]   cur_lane;
  logic [IDX_W-1:0]    commit_idx;
  logic [VEC_W-1:0]    commit_vec;

  logic [VEC_W-1:0]    mem [DEPTH];
  logic [DATA_W-1:0]   staging [LANES];

  // The index port may be wider than DEPTH needs, so range is checked explicitly.
  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(DEPTH);
  endfunction

  // Next-state and handshake decode. In IDLE a pending clr_req wins over a
  // beat, so ld_ready is withheld that cycle to keep the handshake honest.
  always_comb begin
    state_nx    = state;
    clr_cnt_nx  = clr_cnt;
    lane_cnt_nx = lane_cnt;
    busy        = 1'b0;
    ld_ready    = 1'b0;
    accept      = 1'b0;
    commit      = 1'b0;
    clear_wr    = 1'b0;
    unique case (state)
      CLEAR: begin
        busy     = 1'b1;
        clear_wr = 1'b1;
        if (clr_cnt == LAST_ENTRY) begin
          state_nx   = IDLE;
          clr_cnt_nx = '0;
        end else begin
          clr_cnt_nx = clr_cnt + 1'b1;
        end
      end
      IDLE: begin
        ld_ready = !clr_req;
        if (clr_req) begin
          state_nx   = CLEAR;
          clr_cnt_nx = '0;
        end else if (ld_valid) begin
          accept = 1'b1;
          if (LANES == 1) begin
            commit = 1'b1;
          end else begin
            state_nx    = LOAD;
            lane_cnt_nx = LANE_W'(1);
          end
        end
      end
      LOAD: begin
        busy     = 1'b1;
        ld_ready = 1'b1;
        if (ld_valid) begin
          accept = 1'b1;
          if (lane_cnt == LAST_LANE) begin
            commit      = 1'b1;
            state_nx    = IDLE;
            lane_cnt_nx = '0;
          end else begin
            lane_cnt_nx = lane_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nx    = CLEAR;
        clr_cnt_nx  = '0;
        lane_cnt_nx = '0;
      end
    endcase
  end

  // The first beat arrives in IDLE and targets lane 0 and ld_idx directly;
  // later beats use the lane counter and the latched target.
  assign cur_lane   = (state == LOAD) ? lane_cnt : '0;
  assign commit_idx = (state == LOAD) ? target : ld_idx;

  // The committed vector is the staged lanes with the current beat merged in,
  // so the final lane never has to pass through staging first.
  always_comb begin
    commit_vec = '0;
    for (int k = 0; k < LANES; k++) begin
      commit_vec[k*DATA_W +: DATA_W] = (LANE_W'(k) == cur_lane) ? ld_data : staging[k];
    end
  end

  // Control state and registered outputs. Reads sample the array before any
  // same-edge commit lands, giving read-before-write on a collision. A read
  // during the sweep reports zero regardless of how far the sweep has got.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      lane_cnt <= '0;
      target   <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
      ld_err   <= 1'b0;
    end else begin
      state    <= state_nx;
      clr_cnt  <= clr_cnt_nx;
      lane_cnt <= lane_cnt_nx;
      if (accept && state == IDLE) begin
        target <= ld_idx;
      end
      rd_valid <= rd_en;
      rd_err   <= rd_en && !idx_ok(rd_idx);
      if (rd_en) begin
        rd_data <= (idx_ok(rd_idx) && state != CLEAR) ? mem[rd_idx] : '0;
      end
      ld_err <= commit && !idx_ok(commit_idx);
    end
  end

  // Storage has no reset; the clear sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (accept) begin
      staging[cur_lane] <= ld_data;
    end
    if (clear_wr) begin
      mem[clr_cnt] <= '0;
    end else if (commit && idx_ok(commit_idx)) begin
      mem[commit_idx] <= commit_vec;
    end
  end

endmodule
